// File: rtl/core_mem_pkg.sv
// Shared types for the memory stage and the MEM/WB register of the 16-bit core.
package core_mem_pkg;

    localparam int unsigned DEFAULT_ARQ = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    typedef struct packed {
        logic                   mem_rd_mux;
        logic                   wb_enable;
        logic                   pc_en;
        logic [DEFAULT_ARQ-1:0] alu_result;
        logic [DEFAULT_ARQ-1:0] mem_result;
        logic [DEFAULT_ARQ-1:0] wb_imm;
        logic [2:0]             wb_dest;
    } wb_bundle_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts enabled cycles and flags the last allowed one.
module mem_timeout_ctr #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues one data-memory access per load/store over req/ack, stalls
// upstream while it is outstanding and presents the write-back bundle.
module mem_access_stage
    import core_mem_pkg::*;
#(
    parameter int unsigned ARQ     = DEFAULT_ARQ,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic           mem_read_in,
    input  logic           mem_write_in,
    input  logic [ARQ-1:0] alu_result_in,
    input  logic [ARQ-1:0] store_data_in,
    input  logic           wb_enable_in,
    input  logic           mem_rd_mux_in,
    input  logic           pc_en_in,
    input  logic [ARQ-1:0] wb_imm_in,
    input  logic [2:0]     wb_dest_in,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [ARQ-1:0] dmem_addr,
    output logic [ARQ-1:0] dmem_wdata,
    input  logic           dmem_ack,
    input  logic [ARQ-1:0] dmem_rdata,
    output logic           stall_out,
    output logic           mem_rd_mux_out,
    output logic           wb_enable_out,
    output logic           pc_en_out,
    output logic [ARQ-1:0] alu_result_out,
    output logic [ARQ-1:0] mem_result_out,
    output logic [ARQ-1:0] wb_imm_out,
    output logic [2:0]     wb_dest_out,
    output logic           bus_err_out
);

    mem_state_t state;
    wb_bundle_t lat_q;   // latched EX/MEM fields; mem_result is the result register
    wb_bundle_t bundle;
    logic       err_q;
    logic       mem_op;
    logic       expired;

    assign mem_op = valid_in & (mem_read_in | mem_write_in);

    mem_timeout_ctr #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ACCESS),
        .en     (state == ACCESS),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wdata <= '0;
            lat_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        lat_q.mem_rd_mux <= mem_rd_mux_in;
                        lat_q.wb_enable  <= wb_enable_in;
                        lat_q.pc_en      <= pc_en_in;
                        lat_q.alu_result <= alu_result_in;
                        lat_q.mem_result <= '0;
                        lat_q.wb_imm     <= wb_imm_in;
                        lat_q.wb_dest    <= wb_dest_in;
                        dmem_req         <= 1'b1;
                        dmem_we          <= mem_write_in;  // write wins over read
                        dmem_wdata       <= store_data_in;
                        err_q            <= 1'b0;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the final allowed cycle beats the timeout.
                    if (dmem_ack) begin
                        lat_q.mem_result <= dmem_we ? '0 : dmem_rdata;
                        dmem_req         <= 1'b0;
                        dmem_we          <= 1'b0;
                        state            <= DONE;
                    end else if (expired) begin
                        lat_q.mem_result <= '0;
                        dmem_req         <= 1'b0;
                        dmem_we          <= 1'b0;
                        err_q            <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem_addr = lat_q.alu_result;

    always_comb begin
        bundle      = '0;
        stall_out   = 1'b0;
        bus_err_out = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        stall_out = 1'b1;
                    end else begin
                        bundle.wb_enable  = wb_enable_in & valid_in;
                        bundle.pc_en      = pc_en_in;
                        bundle.alu_result = alu_result_in;
                        bundle.wb_imm     = wb_imm_in;
                        bundle.wb_dest    = wb_dest_in;
                    end
                end
                ACCESS: stall_out = 1'b1;
                DONE: begin
                    bundle           = lat_q;
                    bundle.wb_enable = lat_q.wb_enable & ~err_q;
                    bus_err_out      = err_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_mux_out = bundle.mem_rd_mux;
    assign wb_enable_out  = bundle.wb_enable;
    assign pc_en_out      = bundle.pc_en;
    assign alu_result_out = bundle.alu_result;
    assign mem_result_out = bundle.mem_result;
    assign wb_imm_out     = bundle.wb_imm;
    assign wb_dest_out    = bundle.wb_dest;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a bench-driven data memory.
module tb_mem_access_stage;
    import core_mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read_in, mem_write_in, wb_enable_in, mem_rd_mux_in, pc_en_in;
    logic [15:0] alu_result_in, store_data_in, wb_imm_in;
    logic [2:0]  wb_dest_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_out, mem_rd_mux_out, wb_enable_out, pc_en_out, bus_err_out;
    logic [15:0] alu_result_out, mem_result_out, wb_imm_out;
    logic [2:0]  wb_dest_out;

    int total = 0;
    int bad = 0;
    wb_bundle_t exp_q[$];
    int   req_starts = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_prev <= dmem_req;
        if (dmem_req && !req_prev) req_starts <= req_starts + 1;
    end

    mem_access_stage #(
        .ARQ    (16),
        .TIMEOUT(TO),
        .CNT_W  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .alu_result_in (alu_result_in),
        .store_data_in (store_data_in),
        .wb_enable_in  (wb_enable_in),
        .mem_rd_mux_in (mem_rd_mux_in),
        .pc_en_in      (pc_en_in),
        .wb_imm_in     (wb_imm_in),
        .wb_dest_in    (wb_dest_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .stall_out     (stall_out),
        .mem_rd_mux_out(mem_rd_mux_out),
        .wb_enable_out (wb_enable_out),
        .pc_en_out     (pc_en_out),
        .alu_result_out(alu_result_out),
        .mem_result_out(mem_result_out),
        .wb_imm_out    (wb_imm_out),
        .wb_dest_out   (wb_dest_out),
        .bus_err_out   (bus_err_out)
    );

    function automatic wb_bundle_t observed();
        observed = {mem_rd_mux_out, wb_enable_out, pc_en_out, alu_result_out,
                    mem_result_out, wb_imm_out, wb_dest_out};
    endfunction

    task automatic zero_inputs();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0; wb_enable_in = 0;
        mem_rd_mux_in = 0; pc_en_in = 0; alu_result_in = 0; store_data_in = 0;
        wb_imm_in = 0; wb_dest_in = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Issue one instruction; ack_at is the 1-based ACCESS cycle carrying the ack (0 = never).
    task automatic run_op(input string name, input logic rd, input logic wr, input logic wb_en,
                          input logic mux, input logic pce, input logic [15:0] alu,
                          input logic [15:0] sd, input logic [15:0] imm, input logic [2:0] dest,
                          input logic [15:0] rdata, input int ack_at);
        wb_bundle_t exp_b, got_b;
        logic is_mem, exp_err;
        int exp_acc, exp_stall, stall_n, acc_n;
        bit done;
        is_mem   = rd | wr;
        exp_err  = is_mem && (ack_at < 1 || ack_at > TO);
        exp_acc  = !is_mem ? 0 : (exp_err ? TO : ack_at);
        exp_stall = is_mem ? exp_acc + 1 : 0;
        exp_b.mem_rd_mux = is_mem ? mux : 1'b0;
        exp_b.wb_enable  = wb_en & ~exp_err;
        exp_b.pc_en      = pce;
        exp_b.alu_result = alu;
        exp_b.mem_result = (rd && !wr && !exp_err) ? rdata : 16'h0;
        exp_b.wb_imm     = imm;
        exp_b.wb_dest    = dest;

        @(posedge clk); #1;
        valid_in = 1; mem_read_in = rd; mem_write_in = wr; wb_enable_in = wb_en;
        mem_rd_mux_in = mux; pc_en_in = pce; alu_result_in = alu; store_data_in = sd;
        wb_imm_in = imm; wb_dest_in = dest; dmem_ack = 0;
        exp_q.push_back(exp_b);

        stall_n = 0; acc_n = 0; done = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (dmem_req) begin
                acc_n++;
                total++;
                if (dmem_we !== wr || dmem_addr !== alu || (wr && dmem_wdata !== sd)) begin
                    bad++;
                    $display("FAIL %s req_fields: got we=%b addr=%h wdata=%h need we=%b addr=%h wdata=%h",
                             name, dmem_we, dmem_addr, dmem_wdata, wr, alu, sd);
                end
                if (acc_n == ack_at) begin
                    dmem_ack = 1; dmem_rdata = rdata;
                end
            end
            if (!stall_out) begin
                done = 1;
                got_b = observed();
                exp_b = exp_q.pop_front();
                total++;
                if (got_b !== exp_b) begin
                    bad++;
                    $display("FAIL %s bundle: got %h need %h", name, got_b, exp_b);
                end
                total++;
                if (stall_n != exp_stall) begin
                    bad++;
                    $display("FAIL %s stall_cycles: got %0d need %0d", name, stall_n, exp_stall);
                end
                total++;
                if (acc_n != exp_acc) begin
                    bad++;
                    $display("FAIL %s access_cycles: got %0d need %0d", name, acc_n, exp_acc);
                end
                total++;
                if (bus_err_out !== exp_err) begin
                    bad++;
                    $display("FAIL %s bus_err: got %b need %b", name, bus_err_out, exp_err);
                end
            end else begin
                stall_n++;
                total++;
                if (bus_err_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s bus_err_during_stall: got %b need 0", name, bus_err_out);
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                dmem_ack = 0;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s no_completion: got stall after 300 cycles need release", name);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        zero_inputs();
        rst = 1;
        valid_in = 1; mem_read_in = 1; wb_enable_in = 1; pc_en_in = 1;
        alu_result_in = 16'h5A5A; wb_dest_in = 3'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (stall_out !== 0 || dmem_req !== 0 || dmem_we !== 0 || bus_err_out !== 0) begin
            bad++;
            $display("FAIL reset_ctrl: got stall=%b req=%b we=%b err=%b need 0 0 0 0",
                     stall_out, dmem_req, dmem_we, bus_err_out);
        end
        total++;
        if (observed() !== '0) begin
            bad++;
            $display("FAIL reset_bundle: got %h need 0", observed());
        end
        @(posedge clk); #1;
        rst = 0;
        zero_inputs();
    endtask

    task automatic test_idle_ack();
        @(posedge clk); #1;
        wb_enable_in = 1; dmem_ack = 1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        total++;
        if (stall_out !== 0 || wb_enable_out !== 0 || dmem_req !== 0) begin
            bad++;
            $display("FAIL idle_invalid: got stall=%b wb_en=%b req=%b need 0 0 0",
                     stall_out, wb_enable_out, dmem_req);
        end
        @(posedge clk); #1;
        zero_inputs();
        @(negedge clk);
        total++;
        if (stall_out !== 0 || dmem_req !== 0 || bus_err_out !== 0 || observed() !== '0) begin
            bad++;
            $display("FAIL idle_ack_ignored: got stall=%b req=%b err=%b bundle=%h need all 0",
                     stall_out, dmem_req, bus_err_out, observed());
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        zero_inputs();
        valid_in = 1; mem_read_in = 1; wb_enable_in = 1; alu_result_in = 16'h0077;
        @(posedge clk); #1;                 // now in the 1st ACCESS cycle
        @(posedge clk); #1;                 // 2nd ACCESS cycle
        zero_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0; dmem_ack = 1; dmem_rdata = 16'h1111;
        @(negedge clk);
        total++;
        if (dmem_req !== 0 || stall_out !== 0 || bus_err_out !== 0 || observed() !== '0) begin
            bad++;
            $display("FAIL rst_mid_access: got req=%b stall=%b err=%b bundle=%h need all 0",
                     dmem_req, stall_out, bus_err_out, observed());
        end
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk);
        total++;
        if (dmem_req !== 0 || stall_out !== 0 || bus_err_out !== 0 || observed() !== '0) begin
            bad++;
            $display("FAIL rst_late_ack: got req=%b stall=%b err=%b bundle=%h need all 0",
                     dmem_req, stall_out, bus_err_out, observed());
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = req_starts;
        run_op("b2b_ld1", 1, 0, 1, 1, 1, 16'h0001, 16'h0, 16'h0100, 3'd1, 16'hA001, 1);
        run_op("b2b_ld2", 1, 0, 1, 1, 1, 16'h0002, 16'h0, 16'h0200, 3'd2, 16'hA002, 1);
        @(negedge clk);
        total++;
        if (req_starts - start != 2) begin
            bad++;
            $display("FAIL b2b_req_count: got %0d need 2", req_starts - start);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ack();
        run_op("nonmem", 0, 0, 1, 1, 1, 16'h1234, 16'h9999, 16'h00C3, 3'd3, 16'h0, 0);
        run_op("load", 1, 0, 1, 1, 1, 16'h0040, 16'h0, 16'h0004, 3'd5, 16'hBEEF, 1);
        run_op("store", 0, 1, 0, 0, 1, 16'h0010, 16'h00AA, 16'h0, 3'd0, 16'h5555, 5);
        run_op("timeout", 1, 0, 1, 1, 1, 16'h0020, 16'h0, 16'h0, 3'd6, 16'hCAFE, 0);
        run_op("ack_at_limit", 1, 0, 1, 1, 0, 16'h0030, 16'h0, 16'h0007, 3'd4, 16'h7E57, TO);
        run_op("rd_and_wr", 1, 1, 0, 0, 1, 16'h0050, 16'h0F0F, 16'h0, 3'd2, 16'hFFFF, 2);
        test_back_to_back();
        test_reset_mid_access();
        run_op("after_rst", 1, 0, 1, 1, 1, 16'h0060, 16'h0, 16'h0001, 3'd7, 16'h4242, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
